// File: rtl/decode_queue_pkg.sv
// DecodeQueueTypes: shared types and constants for the decode queue.
//   BasicData/RegAddr     : 32-bit data word and 5-bit register index.
//   OpInfo                : decoded control bundle presented to issue.
//   QueueEntry            : one queue slot {inst, pc}.
//   DecodedLane           : full decode result of one presented lane.
//   OPC_* / F7_*          : RV32I opcode and funct7 constants used by the decoder.
// Optional feature macro: RV32M_DECODE_EN (consumed by decode_lane).
package DecodeQueueTypes;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef logic [31:0] BasicData;
  typedef logic [4:0]  RegAddr;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } AluCode;

  // Order matches the M-extension funct3 encoding so funct3 can be cast directly.
  typedef enum logic [2:0] {
    MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU,
    MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU
  } MulDivCode;

  typedef struct packed {
    logic      isBubble;
    logic      wEnable;
    logic      isBranch;
    logic      isLoad;
    logic      isStore;
    logic      isJump;
    logic      isMulDiv;
    logic      useImm;
    logic      usePc;
    AluCode    aluCode;
    MulDivCode mulDivCode;
  } OpInfo;

  typedef struct packed {
    BasicData inst;
    BasicData pc;
  } QueueEntry;

  typedef struct packed {
    OpInfo    op;
    BasicData imm;
    RegAddr   rs1;
    RegAddr   rs2;
    RegAddr   rd;
    BasicData pc;
    logic     illegal;
  } DecodedLane;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // A bubble: no side effects at all downstream.
  function automatic OpInfo bubble_op();
    OpInfo op;
    op            = '0;
    op.isBubble   = ENABLE;
    op.aluCode    = ALU_NONE;
    op.mulDivCode = MULDIV_MUL;
    return op;
  endfunction

  // alt selects SUB/SRA for the 000/101 funct3 slots.
  function automatic AluCode alu_from_funct3(input logic [2:0] f3, input logic alt);
    AluCode code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/decode_queue_decode_lane.sv
// decode_lane: combinational RV32I decoder for one presented queue entry.
//   valid : lane holds a real instruction; when low every output is a zeroed bubble.
//   entry : {inst, pc} from the queue.
//   lane  : decoded OpInfo, immediate, raw register fields, pc and illegal flag.
// Optional feature macro: RV32M_DECODE_EN (decode OP funct7=0000001 as mul/div;
// otherwise those encodings are illegal and isMulDiv stays DISABLE).
module decode_lane
  import DecodeQueueTypes::*;
(
  input  logic       valid,
  input  QueueEntry  entry,
  output DecodedLane lane
);

  BasicData   inst;
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  BasicData   imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst  = entry.inst;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  OpInfo    op;
  BasicData imm;
  logic     illegal;
  logic     writes;
  logic     no_rd;

  always_comb begin
    op          = bubble_op();
    op.isBubble = DISABLE;
    imm         = '0;
    illegal     = 1'b0;
    writes      = 1'b0;
    no_rd       = 1'b0;
    case (opc)
      OPC_OP_IMM: begin
        writes    = 1'b1;
        op.useImm = ENABLE;
        imm       = imm_i;
        // inst[30] is only an opcode bit for the right shifts; elsewhere it is immediate.
        op.aluCode = alu_from_funct3(f3, (f3 == 3'b101) && inst[30]);
        if (f3 == 3'b001 && f7 != F7_BASE) illegal = 1'b1;
        if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) illegal = 1'b1;
      end
      OPC_OP: begin
        writes = 1'b1;
        if (f7 == F7_BASE) begin
          op.aluCode = alu_from_funct3(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          op.aluCode = alu_from_funct3(f3, 1'b1);
        end else if (f7 == F7_MULDIV) begin
`ifdef RV32M_DECODE_EN
          op.isMulDiv   = ENABLE;
          op.mulDivCode = MulDivCode'(f3);
          op.aluCode    = ALU_NONE;
`else
          illegal = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        writes = 1'b1; op.useImm = ENABLE; op.aluCode = ALU_ADD; imm = imm_u;
      end
      OPC_AUIPC: begin
        writes = 1'b1; op.useImm = ENABLE; op.usePc = ENABLE; op.aluCode = ALU_ADD; imm = imm_u;
      end
      OPC_JAL: begin
        writes = 1'b1; op.isJump = ENABLE; op.usePc = ENABLE; op.aluCode = ALU_ADD; imm = imm_j;
      end
      OPC_JALR: begin
        writes = 1'b1; op.isJump = ENABLE; op.useImm = ENABLE; op.aluCode = ALU_ADD; imm = imm_i;
      end
      OPC_BRANCH: begin
        no_rd = 1'b1; op.isBranch = ENABLE; op.aluCode = ALU_SUB; imm = imm_b;
        if (f3 == 3'b010 || f3 == 3'b011) illegal = 1'b1;
      end
      OPC_STORE: begin
        no_rd = 1'b1; op.isStore = ENABLE; op.useImm = ENABLE; op.aluCode = ALU_ADD; imm = imm_s;
        if (f3 > 3'b010) illegal = 1'b1;
      end
      OPC_LOAD: begin
        writes = 1'b1; op.isLoad = ENABLE; op.useImm = ENABLE; op.aluCode = ALU_ADD; imm = imm_i;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) illegal = 1'b1;
    // Writes to x0 are dropped here so issue never has to special-case rd=0.
    op.wEnable = writes && (inst[11:7] != 5'd0);

    lane = '0;
    if (valid) begin
      // Illegal lanes stay valid so the exception can be raised, but carry no work.
      lane.op      = illegal ? bubble_op() : op;
      lane.imm     = imm;
      lane.rs1     = inst[19:15];
      lane.rs2     = inst[24:20];
      lane.rd      = no_rd ? 5'd0 : inst[11:7];
      lane.pc      = entry.pc;
      lane.illegal = illegal;
    end else begin
      lane.op = bubble_op();
    end
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: circular instruction queue feeding DECODE_WIDTH decode lanes.
//   clk, rst        : clock and synchronous active-high reset.
//   flush           : drop everything queued/presented at the next edge.
//   fetchValid/Inst/Pc, fetchReady : fetch group input; whole group taken only when ready.
//   decValid/OpInfo/Imm/Rs1/Rs2/Rd/Pc/Illegal : decoded head lanes (contiguous prefix).
//   decAccept       : number of prefix lanes consumed this cycle.
//   occupancy       : current entry count.
// Optional feature macro: RV32M_DECODE_EN (mul/div decode inside decode_lane).
module decode_queue
  import DecodeQueueTypes::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int QUEUE_DEPTH  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [FETCH_WIDTH-1:0]                fetchValid,
  input  logic [FETCH_WIDTH-1:0][31:0]          fetchInst,
  input  logic [FETCH_WIDTH-1:0][31:0]          fetchPc,
  output logic                                  fetchReady,
  output logic [DECODE_WIDTH-1:0]               decValid,
  output OpInfo [DECODE_WIDTH-1:0]              decOpInfo,
  output logic [DECODE_WIDTH-1:0][31:0]         decImm,
  output logic [DECODE_WIDTH-1:0][4:0]          decRs1,
  output logic [DECODE_WIDTH-1:0][4:0]          decRs2,
  output logic [DECODE_WIDTH-1:0][4:0]          decRd,
  output logic [DECODE_WIDTH-1:0][31:0]         decPc,
  output logic [DECODE_WIDTH-1:0]               decIllegal,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]     decAccept,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]      occupancy
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int ACC_W = $clog2(DECODE_WIDTH + 1);

  QueueEntry        queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;

  // push_off[i] = number of valid lanes below lane i, i.e. lane i's slot offset from tail.
  logic [CNT_W-1:0] push_off [FETCH_WIDTH+1];
  logic [CNT_W-1:0] push_cnt;
  logic [ACC_W-1:0] present_cnt;
  logic [ACC_W-1:0] accept_cnt;

  assign push_off[0] = '0;
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_push_off
    assign push_off[gi+1] = push_off[gi] + CNT_W'(fetchValid[gi]);
  end

  // Only the registered count matters: space freed by a same-cycle pop is not reused.
  assign fetchReady = (CNT_W'(QUEUE_DEPTH) - count_reg) >= CNT_W'(FETCH_WIDTH);
  assign push_cnt   = fetchReady ? push_off[FETCH_WIDTH] : '0;
  assign occupancy  = count_reg;

  assign present_cnt = (count_reg >= CNT_W'(DECODE_WIDTH)) ? ACC_W'(DECODE_WIDTH)
                                                           : ACC_W'(count_reg);
  // Over-acceptance is clamped so the pointers can never pass the tail.
  assign accept_cnt  = (decAccept > present_cnt) ? present_cnt : decAccept;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PTR_W'(accept_cnt);
      tail_reg  <= tail_reg + PTR_W'(push_cnt);
      count_reg <= count_reg + push_cnt - CNT_W'(accept_cnt);
    end
  end

  // Storage has no reset: unoccupied slots are never presented as valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!rst && !flush && fetchReady && fetchValid[i]) begin
        queue_mem[tail_reg + PTR_W'(push_off[i])] <= '{inst: fetchInst[i], pc: fetchPc[i]};
      end
    end
  end

  for (genvar gi = 0; gi < DECODE_WIDTH; gi++) begin : g_lane
    logic [PTR_W-1:0] rd_idx;
    DecodedLane       lane_out;

    assign rd_idx       = head_reg + PTR_W'(gi);
    assign decValid[gi] = CNT_W'(gi) < count_reg;

    decode_lane u_lane (
      .valid (decValid[gi]),
      .entry (queue_mem[rd_idx]),
      .lane  (lane_out)
    );

    assign decOpInfo[gi]  = lane_out.op;
    assign decImm[gi]     = lane_out.imm;
    assign decRs1[gi]     = lane_out.rs1;
    assign decRs2[gi]     = lane_out.rs2;
    assign decRd[gi]      = lane_out.rd;
    assign decPc[gi]      = lane_out.pc;
    assign decIllegal[gi] = lane_out.illegal;
  end

  a_accept_in_range: assert property (@(posedge clk) disable iff (rst) decAccept <= present_cnt);

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Multi-lane decode stage with an instruction queue, placed between fetch and issue/register-read.
- Buffers fetched instruction words and their PCs in a circular queue.
- Decodes up to DECODE_WIDTH head entries per cycle into OpInfo, immediate and register addresses, and detects illegal encodings.
- Backpressure is handled by a fetch-side ready and a downstream accept count; a flush input supports branch-mispredict recovery.

Parameters:
- FETCH_WIDTH, 2: instructions offered per cycle by fetch.
- DECODE_WIDTH, 2: decoded lanes presented per cycle.
- QUEUE_DEPTH, 8: queue entries; power of two, at least FETCH_WIDTH + DECODE_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued and presented instructions.
- fetchValid  in  FETCH_WIDTH  per-lane valid.
- fetchInst  in  FETCH_WIDTH x 32  instruction words.
- fetchPc  in  FETCH_WIDTH x 32  PCs.
- fetchReady  out  1  queue can take a full fetch group this cycle.
- decValid  out  DECODE_WIDTH  per-lane valid; always a contiguous prefix.
- decOpInfo  out  DECODE_WIDTH x OpInfo  decoded control.
- decImm  out  DECODE_WIDTH x 32  immediate.
- decRs1, decRs2, decRd  out  DECODE_WIDTH x 5  register addresses.
- decPc  out  DECODE_WIDTH x 32  PC per lane.
- decIllegal  out  DECODE_WIDTH  illegal-instruction flag.
- decAccept  in  $clog2(DECODE_WIDTH+1)  number of prefix lanes consumed downstream this cycle.
- occupancy  out  $clog2(QUEUE_DEPTH+1)  current entry count.

Behaviour:
- Reset: one clock; reset is synchronous and active-high on rst, sampled at the clk rising edge.
  - Clears head, tail and count to 0.
  - Leaves fetchReady=1 and all decValid=0.
- Queue: circular buffer of {inst, pc} with head/tail pointers modulo QUEUE_DEPTH; wrap-around is natural.
- Push:
  - fetchReady = (QUEUE_DEPTH - count) >= FETCH_WIDTH, computed from the registered count only. Entries freed by a same-cycle pop are not counted.
  - When fetchReady=1, valid fetch lanes are written in lane order to consecutive slots from tail, and tail advances by popcount(fetchValid).
  - Non-contiguous valid lanes are compacted; e.g. valid=10 writes lane1 into slot tail.
  - When fetchReady=0, fetch inputs are ignored and fetch must hold them.
- Present: lane i shows queue[head+i] when i < count; outputs are combinational from registered queue state.
  - Push-to-output latency: an instruction pushed in cycle N is presented from cycle N+1 (one cycle).
- Pop: head advances by decAccept and count updates as count + pushed - decAccept.
  - decAccept greater than popcount(decValid) is a protocol violation: simulation assertion fires and the value is clamped to popcount(decValid).
- Invalid lanes: decOpInfo has isBubble=ENABLE, wEnable=DISABLE, isBranch/isLoad/isStore=DISABLE; decImm, decPc and register addresses are 0; decIllegal=0.
- Decode follows the team's RV32I decode rules per opcode (OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, STORE, LOAD).
- decIllegal=1 for any of:
  - an unknown opcode;
  - inst[1:0] != 2'b11;
  - BRANCH funct3 of 010 or 011;
  - STORE funct3 above 010;
  - LOAD funct3 of 011, 110 or 111;
  - OP-IMM shift with a bad funct7;
  - OP with an undefined funct7.
- Illegal lanes: decOpInfo is forced to a bubble with wEnable=DISABLE, while decValid stays 1 so downstream can raise an exception.
- decRs1, decRs2 and decRd carry the raw inst fields; decRd is 0 for B and S types.
- Flush: at the next edge sets head=tail=count=0.
  - Overrides push and pop in the same cycle.
  - decValid=0 from the following cycle.
  - rst and flush together behave as rst.
- Full and empty:
  - count=QUEUE_DEPTH gives fetchReady=0.
  - count=0 gives all decValid=0.
  - Simultaneous push and pop at any count must keep count within 0..QUEUE_DEPTH.

Optional Feature:
- Macro: RV32M_DECODE_EN.
- Defined: OP with funct7=0000001 decodes to isMulDiv=ENABLE with mulDivCode MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU according to funct3, and aluCode=ALU_NONE.
- Undefined: the same encodings raise decIllegal=1, and isMulDiv is tied to DISABLE.

Decomposition:
- Package DecodeQueueTypes:
  - QueueEntry struct {BasicData inst; BasicData pc}.
  - DecodedLane struct {OpInfo, imm, rs1, rs2, rd, pc, illegal}.
  - Opcode constants for the illegal check.
- Sub-module decode_lane: combinational single-instruction decoder plus illegal detection, instantiated DECODE_WIDTH times.
- The queue and pointer logic live in decode_queue.

Test Plan:
- Reset, push {0x00500093 (addi x1,x0,5), 0x002081B3 (add x3,x1,x2)} at pc 0x0/0x4 -> next cycle decValid=11, lane0 aluCode=ALU_ADD, decImm=5, decRd=1; lane1 decRs1=1, decRs2=2, decRd=3.
- Push with decAccept=0 until full (QUEUE_DEPTH=8, 4 groups) -> fetchReady=0 once occupancy=8, and the 5th group is not written. Then accept 2 -> fetchReady=1 the following cycle.
- Fill 6 entries, accept 2 per cycle while pushing 2 per cycle across the index 7->0 wrap -> PCs emerge strictly in order with no loss or duplication.
- Push 0x0000007F (illegal opcode) -> decValid=1, decIllegal=1, isBubble=ENABLE, wEnable=DISABLE.
- Push 0x02208033 (mul x0? no: mul x0,x1,x2) -> with RV32M_DECODE_EN, isMulDiv=ENABLE, mulDivCode=MULDIV_MUL, wEnable=DISABLE (rd=0); without the macro, decIllegal=1.
- Occupancy 5 with flush and a push in the same cycle -> occupancy=0 and decValid=00 on the next cycle, and the pushed group is discarded.
